// File: rtl/serial_acc_bank.sv
`default_nettype none
// ============================================================================
// Module : serial_acc_bank
// Bank of accumulators: parallel load, or LSB-first digit-serial rewrite
// that streams the old contents out while the new digits are written.
// Rev    : 1.0
// ============================================================================
module serial_acc_bank #(
  parameter  int WIDTH   = 8,
  parameter  int DIGIT   = 1,
  parameter  int NUM_ACC = 2,
  localparam int NDIG    = WIDTH / DIGIT,
  localparam int IW      = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int SW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW-1:0]    acc_sel,
  input  logic             acc_load_en,
  input  logic [WIDTH-1:0] acc_parallel_in,
  input  logic             acc_write_en,
  input  logic [DIGIT-1:0] alu_result,
  output logic [DIGIT-1:0] acc_serial_out,
  output logic [WIDTH-1:0] acc_bits,
  output logic [IW-1:0]    digit_index,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  state_t                        state_q, state_d;
  logic [NUM_ACC-1:0][WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [SW-1:0]                 act_q, act_d;
  logic                          done_q, done_d;

  logic                          sel_ok;
  logic                          load_hit;
  logic [WIDTH-1:0]              sel_word;
  logic [WIDTH-1:0]              act_word;
  logic [WIDTH-1:0]              rd_word;

  // Select codes at or above NUM_ACC exist only when NUM_ACC is not a power of 2.
  if (NUM_ACC == (1 << SW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_partial
    assign sel_ok = ({1'b0, acc_sel} < (SW + 1)'(NUM_ACC));
  end

  assign load_hit = acc_load_en && sel_ok;

  always_comb begin
    sel_word = '0;
    act_word = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (acc_sel == SW'(i)) sel_word = acc_q[i];
      if (act_q == SW'(i))   act_word = acc_q[i];
    end
    if (!sel_ok) sel_word = '0;
  end

  // In IDLE the index rests at 0, so this shows digit 0 of the selected acc.
  assign rd_word = (state_q == ST_SHIFT) ? act_word : sel_word;

  always_comb begin
    acc_serial_out = '0;
    for (int d = 0; d < NDIG; d++) begin
      if (idx_q == IW'(d)) acc_serial_out = rd_word[d*DIGIT +: DIGIT];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    act_d   = act_q;
    done_d  = 1'b0;

    if (load_hit) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (acc_sel == SW'(i)) acc_d[i] = acc_parallel_in;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!load_hit && acc_write_en && sel_ok) begin
          act_d   = acc_sel;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (load_hit) begin
          // A load mid-pass abandons the pass without a done pulse.
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          for (int i = 0; i < NUM_ACC; i++) begin
            for (int d = 0; d < NDIG; d++) begin
              if (act_q == SW'(i) && idx_q == IW'(d)) begin
                acc_d[i][d*DIGIT +: DIGIT] = alu_result;
              end
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      act_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign acc_bits    = sel_word;
  assign digit_index = idx_q;
  assign busy        = (state_q == ST_SHIFT);
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_acc_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_acc_bank
// Scoreboard bench: bit-serial bank (A) plus a 4-bit-digit, 3-entry bank (B).
// Rev    : 1.0
// ============================================================================
module tb_serial_acc_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Bank A: WIDTH=8, DIGIT=1, NUM_ACC=2
  logic       a_sel, a_load, a_wr;
  logic [7:0] a_pin, a_bits;
  logic [0:0] a_alu, a_sout;
  logic [2:0] a_idx;
  logic       a_busy, a_done;

  // Bank B: WIDTH=8, DIGIT=4, NUM_ACC=3
  logic [1:0] b_sel;
  logic       b_load, b_wr;
  logic [7:0] b_pin, b_bits;
  logic [3:0] b_alu, b_sout;
  logic [0:0] b_idx;
  logic       b_busy, b_done;

  serial_acc_bank #(.WIDTH(8), .DIGIT(1), .NUM_ACC(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .acc_sel(a_sel), .acc_load_en(a_load),
    .acc_parallel_in(a_pin), .acc_write_en(a_wr), .alu_result(a_alu),
    .acc_serial_out(a_sout), .acc_bits(a_bits), .digit_index(a_idx),
    .busy(a_busy), .done(a_done)
  );

  serial_acc_bank #(.WIDTH(8), .DIGIT(4), .NUM_ACC(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .acc_sel(b_sel), .acc_load_en(b_load),
    .acc_parallel_in(b_pin), .acc_write_en(b_wr), .alu_result(b_alu),
    .acc_serial_out(b_sout), .acc_bits(b_bits), .digit_index(b_idx),
    .busy(b_busy), .done(b_done)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mdl[2];
  logic [7:0] pend_val;
  logic       pend_sel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every done pulse on bank A must match the oldest queued pass result.
  always @(posedge clk) begin : p_mon
    logic [7:0] e;
    #1;
    if (a_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", a_bits, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic a_load_acc(input logic sel, input logic [7:0] v);
    a_sel = sel; a_load = 1'b1; a_pin = v;
    @(negedge clk);
    a_load = 1'b0;
    mdl[sel] = v;
    check("load_bits", a_bits, v);
  endtask

  task automatic a_start(input logic sel, input logic [7:0] newval);
    a_sel = sel; a_wr = 1'b1;
    pend_sel = sel; pend_val = newval;
    exp_q.push_back(newval);
  endtask

  // Runs the pass set up by a_start; returns at the negedge of the done cycle.
  task automatic a_shift();
    logic [7:0] old;
    int         busy_cnt;
    old = mdl[pend_sel];
    busy_cnt = 0;
    @(negedge clk);
    a_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("shift_busy", a_busy, 32'd1);
      check("shift_idx", a_idx, k);
      check("shift_sout", a_sout, old[k]);
      check("shift_done", a_done, 32'd0);
      busy_cnt += int'(a_busy);
      a_alu = pend_val[k];
      @(negedge clk);
    end
    check("busy_cycles", busy_cnt, 32'd8);
    check("end_busy", a_busy, 32'd0);
    check("end_done", a_done, 32'd1);
    check("end_bits", a_bits, pend_val);
    mdl[pend_sel] = pend_val;
  endtask

  initial begin
    rst_n = 1'b0;
    a_sel = 1'b0; a_load = 1'b0; a_wr = 1'b0; a_pin = '0; a_alu = '0;
    b_sel = '0;   b_load = 1'b0; b_wr = 1'b0; b_pin = '0; b_alu = '0;
    mdl[0] = '0; mdl[1] = '0;
    repeat (2) @(negedge clk);
    check("rst_bits", a_bits, 32'h0);
    check("rst_busy", a_busy, 32'd0);
    check("rst_done", a_done, 32'd0);
    check("rst_idx", a_idx, 32'd0);
    check("rst_b_bits", b_bits, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of a pass
    a_load_acc(1'b0, 8'hA5);
    a_sel = 1'b0; a_wr = 1'b1;
    @(negedge clk);
    a_wr = 1'b0; a_alu = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", a_busy, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_bits", a_bits, 32'h0);
    check("async_rst_busy", a_busy, 32'd0);
    check("async_rst_done", a_done, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl[0] = '0; mdl[1] = '0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", a_done, 32'd0);
      check("post_rst_busy", a_busy, 32'd0);
    end

    // Invert acc0 in place; acc1 must be untouched
    a_load_acc(1'b0, 8'hA5);
    a_load_acc(1'b1, 8'h3C);
    a_sel = 1'b0;
    #1 check("idle_sout", a_sout, 32'd1);
    a_start(1'b0, ~mdl[0]);
    a_shift();
    a_sel = 1'b1;
    #1 check("acc1_kept", a_bits, 32'h3C);
    @(negedge clk);
    check("done_one_cycle", a_done, 32'd0);

    // Load at idx 3 aborts the pass
    a_sel = 1'b0; a_wr = 1'b1;
    @(negedge clk);
    a_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_alu = 1'(k);
      @(negedge clk);
    end
    check("abort_idx3", a_idx, 32'd3);
    a_load = 1'b1; a_pin = 8'h11;
    @(negedge clk);
    a_load = 1'b0;
    mdl[0] = 8'h11;
    check("abort_busy", a_busy, 32'd0);
    check("abort_bits", a_bits, 32'h11);
    check("abort_idx", a_idx, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", a_done, 32'd0);
    end
    a_start(1'b0, 8'h96);
    a_shift();

    // Simultaneous load and write in IDLE: load only
    @(negedge clk);
    a_sel = 1'b1; a_load = 1'b1; a_wr = 1'b1; a_pin = 8'h77;
    @(negedge clk);
    a_load = 1'b0; a_wr = 1'b0;
    mdl[1] = 8'h77;
    check("lw_busy", a_busy, 32'd0);
    check("lw_bits", a_bits, 32'h77);
    @(negedge clk);
    check("lw_busy2", a_busy, 32'd0);
    check("lw_done", a_done, 32'd0);

    // Back-to-back passes, second one started in the done cycle
    a_start(1'b0, 8'h0F);
    a_shift();
    a_start(1'b1, 8'hE1);
    a_shift();
    a_sel = 1'b0;
    #1 check("acc0_held", a_bits, 32'h0F);
    @(negedge clk);

    // Bank B: 4-bit digits
    b_sel = 2'd0; b_load = 1'b1; b_pin = 8'h3C;
    @(negedge clk);
    b_load = 1'b0; b_wr = 1'b1;
    check("b_load_bits", b_bits, 32'h3C);
    check("b_idle_sout", b_sout, 32'hC);
    @(negedge clk);
    b_wr = 1'b0;
    check("b_busy0", b_busy, 32'd1);
    check("b_idx0", b_idx, 32'd0);
    check("b_sout0", b_sout, 32'hC);
    b_alu = 4'h9;
    @(negedge clk);
    check("b_busy1", b_busy, 32'd1);
    check("b_idx1", b_idx, 32'd1);
    check("b_sout1", b_sout, 32'h3);
    b_alu = 4'h6;
    @(negedge clk);
    check("b_done", b_done, 32'd1);
    check("b_end_busy", b_busy, 32'd0);
    check("b_result", b_bits, 32'h69);
    @(negedge clk);
    check("b_done_clr", b_done, 32'd0);

    // Out-of-range select on bank B
    b_sel = 2'd3; b_load = 1'b1; b_pin = 8'hFF;
    #1;
    check("oor_bits", b_bits, 32'h0);
    check("oor_sout", b_sout, 32'h0);
    @(negedge clk);
    b_load = 1'b0; b_wr = 1'b1;
    @(negedge clk);
    b_wr = 1'b0;
    check("oor_no_pass", b_busy, 32'd0);
    b_sel = 2'd0;
    #1 check("oor_acc0", b_bits, 32'h69);
    b_sel = 2'd2;
    #1 check("oor_acc2", b_bits, 32'h0);
    b_sel = 2'd1;
    #1 check("oor_acc1", b_bits, 32'h0);
    repeat (2) @(negedge clk);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
